// File: rtl/pic8259_pkg.sv
// Shared types and constants for the 8259-style interrupt controller:
// init-sequence states, control-word bit positions and OCW2 command codes.
package pic8259_pkg;

  typedef enum logic [2:0] {
    INIT_ICW1,
    INIT_ICW2,
    INIT_ICW3,
    INIT_ICW4,
    INIT_READY
  } initState_t;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SEL  = 4;
  localparam int ICW4_AEOI = 1;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_RIS  = 0;

  // d[4:3] tag that separates OCW2 from OCW3 once initialized
  localparam logic [1:0] OCW2_TAG = 2'b00;
  localparam logic [1:0] OCW3_TAG = 2'b01;

  localparam logic [2:0] OCW2_CLR_RAEOI = 3'b000;
  localparam logic [2:0] OCW2_NSEOI     = 3'b001;
  localparam logic [2:0] OCW2_NOP       = 3'b010;
  localparam logic [2:0] OCW2_SEOI      = 3'b011;
  localparam logic [2:0] OCW2_SET_RAEOI = 3'b100;
  localparam logic [2:0] OCW2_ROT_NSEOI = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO  = 3'b110;
  localparam logic [2:0] OCW2_ROT_SEOI  = 3'b111;

endpackage

// File: rtl/pic8259_prio.sv
// Rotating priority resolver: highest-priority unmasked request, highest
// in-service level, and whether the request outranks everything in service.
module pic8259_prio (
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  input  logic [2:0] lowest,
  output logic       irqValid,
  output logic [2:0] irqLevel,
  output logic       isrValid,
  output logic [2:0] isrLevel,
  output logic       intReq
);

  logic [2:0] irqRank;
  logic [2:0] isrRank;
  logic [2:0] lvl;

  // Rank 0 is the level just after 'lowest'; scanning down lets the best rank win.
  always_comb begin
    irqValid = 1'b0;
    irqLevel = 3'd0;
    irqRank  = 3'd7;
    isrValid = 1'b0;
    isrLevel = 3'd0;
    isrRank  = 3'd7;
    lvl      = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      lvl = lowest + 3'(k) + 3'd1;
      if (irr[lvl] && !imr[lvl]) begin
        irqValid = 1'b1;
        irqLevel = lvl;
        irqRank  = 3'(k);
      end
      if (isr[lvl]) begin
        isrValid = 1'b1;
        isrLevel = lvl;
        isrRank  = 3'(k);
      end
    end
    intReq = irqValid && (!isrValid || (irqRank < isrRank));
  end

endmodule

// File: rtl/pic8259.sv
// Programmable interrupt controller: ICW/OCW programming, IRR/ISR/IMR,
// rotating priority, two-pulse INTA vector cycle and master/slave cascade.
module pic8259
  import pic8259_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  inout  logic [2:0] cas,
  inout  logic [7:0] d,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic       cs_n,
  input  logic       sp_en,
  input  logic       inta_n,
  input  logic [7:0] ir,
  output logic       int_o
);

  initState_t initState, initNext;

  logic       wrPrev, intaPrev;
  logic [7:0] irPrev, irr, isr, imr, icw3;
  logic [7:0] irrNext, isrNext;
  logic [2:0] lowest, lowestNext;
  logic       ic4, sngl, ltim, aeoi, rotAeoi, ris;
  logic [4:0] base;
  logic [1:0] intaCnt;
  logic [2:0] winner;
  logic       spurious, casActive;

  logic       irqValid, isrValid, intReq;
  logic [2:0] irqLevel, isrLevel;

  logic       wrAct, wrStrobe, ready, icw1Wr, ocw1Wr, ocw2Wr, ocw3Wr;
  logic       intaFall, intaRise, firstAck, secondFall, seqEnd;
  logic       casMaster, casSlave, vecDrive, rdDrive;
  logic [2:0] ocw2Cmd, ocw2Lvl;
  logic [7:0] dOut;

  assign wrAct    = !cs_n && !wr_n;
  assign wrStrobe = wrAct && !wrPrev;
  assign ready    = (initState == INIT_READY);
  assign icw1Wr   = wrStrobe && !a0 && d[ICW1_SEL];
  assign ocw1Wr   = wrStrobe && ready && a0;
  assign ocw2Wr   = wrStrobe && ready && !a0 && (d[4:3] == OCW2_TAG);
  assign ocw3Wr   = wrStrobe && ready && !a0 && (d[4:3] == OCW3_TAG);
  assign ocw2Cmd  = d[7:5];
  assign ocw2Lvl  = d[2:0];

  // Only the start of an INTA sequence needs an initialized device; once
  // begun it runs to completion even if the CPU reprograms in between.
  assign intaFall   = intaPrev && !inta_n;
  assign intaRise   = !intaPrev && inta_n;
  assign firstAck   = intaFall && (intaCnt == 2'd0) && ready;
  assign secondFall = intaFall && (intaCnt == 2'd1);
  assign seqEnd     = intaRise && (intaCnt == 2'd2);

  assign casMaster = !sngl && sp_en;
  assign casSlave  = !sngl && !sp_en;

  pic8259_prio uPrio (
    .irr      (irr),
    .imr      (imr),
    .isr      (isr),
    .lowest   (lowest),
    .irqValid (irqValid),
    .irqLevel (irqLevel),
    .isrValid (isrValid),
    .isrLevel (isrLevel),
    .intReq   (intReq)
  );

  always_comb begin
    initNext = initState;
    if (icw1Wr) begin
      initNext = INIT_ICW2;
    end else if (wrStrobe && a0) begin
      case (initState)
        INIT_ICW2: initNext = !sngl ? INIT_ICW3 : (ic4 ? INIT_ICW4 : INIT_READY);
        INIT_ICW3: initNext = ic4 ? INIT_ICW4 : INIT_READY;
        INIT_ICW4: initNext = INIT_READY;
        default:   initNext = initState;
      endcase
    end
  end

  // Updates applied in order so that a later event in the same cycle wins.
  always_comb begin
    irrNext    = irr | (ltim ? ir : (ir & ~irPrev));
    isrNext    = isr;
    lowestNext = lowest;
    if (firstAck && irqValid) begin
      irrNext[irqLevel] = 1'b0;
      isrNext[irqLevel] = 1'b1;
    end
    if (seqEnd && aeoi && !spurious) begin
      isrNext[winner] = 1'b0;
      if (rotAeoi) lowestNext = winner;
    end
    if (ocw2Wr) begin
      case (ocw2Cmd)
        OCW2_NSEOI: if (isrValid) isrNext[isrLevel] = 1'b0;
        OCW2_ROT_NSEOI: begin
          if (isrValid) begin
            isrNext[isrLevel] = 1'b0;
            lowestNext        = isrLevel;
          end
        end
        OCW2_SEOI: isrNext[ocw2Lvl] = 1'b0;
        OCW2_ROT_SEOI: begin
          isrNext[ocw2Lvl] = 1'b0;
          lowestNext       = ocw2Lvl;
        end
        OCW2_SET_PRIO: lowestNext = ocw2Lvl;
        default: ;
      endcase
    end
    if (icw1Wr) begin
      irrNext    = 8'h00;
      isrNext    = 8'h00;
      lowestNext = 3'd7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      initState <= INIT_ICW1;
      wrPrev    <= 1'b0;
      intaPrev  <= 1'b1;
      irPrev    <= 8'h00;
      irr       <= 8'h00;
      isr       <= 8'h00;
      imr       <= 8'h00;
      icw3      <= 8'h00;
      lowest    <= 3'd7;
      ic4       <= 1'b0;
      sngl      <= 1'b1;
      ltim      <= 1'b0;
      aeoi      <= 1'b0;
      rotAeoi   <= 1'b0;
      ris       <= 1'b0;
      base      <= 5'd0;
      intaCnt   <= 2'd0;
      winner    <= 3'd0;
      spurious  <= 1'b0;
      casActive <= 1'b0;
    end else begin
      initState <= initNext;
      wrPrev    <= wrAct;
      intaPrev  <= inta_n;
      irPrev    <= ir;
      irr       <= irrNext;
      isr       <= isrNext;
      lowest    <= lowestNext;
      if (icw1Wr) begin
        ic4     <= d[ICW1_IC4];
        sngl    <= d[ICW1_SNGL];
        ltim    <= d[ICW1_LTIM];
        imr     <= 8'h00;
        aeoi    <= 1'b0;
        rotAeoi <= 1'b0;
        ris     <= 1'b0;
      end else if (wrStrobe && a0) begin
        case (initState)
          INIT_ICW2: base <= d[7:3];
          INIT_ICW3: icw3 <= d;
          INIT_ICW4: aeoi <= d[ICW4_AEOI];
          default:   if (ocw1Wr) imr <= d;
        endcase
      end
      if (ocw2Wr && (ocw2Cmd == OCW2_SET_RAEOI)) rotAeoi <= 1'b1;
      if (ocw2Wr && (ocw2Cmd == OCW2_CLR_RAEOI)) rotAeoi <= 1'b0;
      if (ocw3Wr && d[OCW3_RR]) ris <= d[OCW3_RIS];
      if (firstAck) begin
        winner    <= irqValid ? irqLevel : 3'd7;
        spurious  <= !irqValid;
        casActive <= casMaster && irqValid && icw3[irqLevel];
        intaCnt   <= 2'd1;
      end else if (secondFall) begin
        intaCnt <= 2'd2;
      end else if (seqEnd) begin
        intaCnt   <= 2'd0;
        casActive <= 1'b0;
      end
    end
  end

  // A cascaded slave answers only when the master puts its ID on cas; a
  // master stays off the bus when the winner belongs to a slave.
  assign vecDrive = (intaCnt == 2'd2) && !inta_n &&
                    (casSlave ? (cas == icw3[2:0]) : !casActive);
  assign rdDrive  = !cs_n && !rd_n;
  assign dOut     = vecDrive ? {base, winner} : (a0 ? imr : (ris ? isr : irr));
  assign d        = (vecDrive || rdDrive) ? dOut : 8'bz;
  assign cas      = (casActive && (intaCnt != 2'd0)) ? winner : 3'bz;
  assign int_o    = ready && (intaCnt == 2'd0) && intReq;

endmodule

// File: tb/tb_pic8259.sv
// Directed and randomized checks of pic8259: programming, priority,
// rotation, INTA vectors, cascade and reset behaviour.
module tb_pic8259;

  logic       clk = 1'b0;
  logic       rst_n, rd_n, wr_n, a0, csM, csS, inta_n, tbDrv;
  logic [7:0] tbData, irTbM, irTbS;
  wire  [7:0] dM, dS, irM;
  wire  [2:0] casW;
  wire        intM, intS;

  int total = 0;
  int bad   = 0;

  logic [7:0] v, vs;
  logic [2:0] c;

  // reference model state for the randomized phase
  logic [7:0] mIrr, mImr, pend, expV;
  logic [4:0] mBase;
  int         mLowest, w;
  bit         mRotAeoi;

  always #5 clk = ~clk;

  // undriven bus bits read as 1, so high-Z shows up as all-ones
  pullup (dM);
  pullup (dS);
  pullup (casW);

  assign dM  = tbDrv ? tbData : 8'bz;
  assign dS  = tbDrv ? tbData : 8'bz;
  assign irM = irTbM | {6'b0, intS, 1'b0};

  pic8259 uMaster (
    .clk(clk), .rst_n(rst_n), .cas(casW), .d(dM), .rd_n(rd_n), .wr_n(wr_n),
    .a0(a0), .cs_n(csM), .sp_en(1'b1), .inta_n(inta_n), .ir(irM), .int_o(intM)
  );

  pic8259 uSlave (
    .clk(clk), .rst_n(rst_n), .cas(casW), .d(dS), .rd_n(rd_n), .wr_n(wr_n),
    .a0(a0), .cs_n(csS), .sp_en(1'b0), .inta_n(inta_n), .ir(irTbS), .int_o(intS)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int dev, input logic addr, input logic [7:0] val);
    @(negedge clk);
    a0 = addr; tbData = val; tbDrv = 1'b1;
    csM = (dev != 0); csS = (dev == 0); wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1; csM = 1'b1; csS = 1'b1;
    @(negedge clk);
    tbDrv = 1'b0;
  endtask

  task automatic rd(input int dev, input logic addr, output logic [7:0] val);
    @(negedge clk);
    a0 = addr; csM = (dev != 0); csS = (dev == 0); rd_n = 1'b0;
    #2 val = (dev == 0) ? dM : dS;
    @(negedge clk);
    rd_n = 1'b1; csM = 1'b1; csS = 1'b1;
  endtask

  task automatic pulseIr(input int dev, input logic [7:0] val);
    @(negedge clk);
    if (dev == 0) irTbM = val; else irTbS = val;
    repeat (2) @(negedge clk);
    irTbM = 8'h00; irTbS = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic intaFirst(output logic [2:0] casObs);
    @(negedge clk);
    inta_n = 1'b0;
    repeat (2) @(negedge clk);
    casObs = casW;
    inta_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic intaSecond(output logic [7:0] vm, output logic [7:0] vsl);
    @(negedge clk);
    inta_n = 1'b0;
    repeat (2) @(negedge clk);
    vm = dM; vsl = dS;
    inta_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic int refWinner(input logic [7:0] p, input int low);
    for (int k = 1; k <= 8; k++) begin
      if (p[(low + k) % 8]) return (low + k) % 8;
    end
    return -1;
  endfunction

  initial begin
    rst_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; csM = 1'b1; csS = 1'b1;
    inta_n = 1'b1; tbDrv = 1'b0; tbData = 8'h00; irTbM = 8'h00; irTbS = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_int", {7'b0, intM}, 8'h00);
    chk("rst_d_hiz", dM, 8'hFF);
    chk("rst_cas_hiz", {5'b0, casW}, 8'h07);
    rst_n = 1'b1;
    rd(0, 1'b1, v); chk("rst_imr", v, 8'h00);
    rd(0, 1'b0, v); chk("rst_irr", v, 8'h00);

    // level mode, AEOI, masked IR1/IR6/IR7
    wr(0, 1'b0, 8'h1B); wr(0, 1'b1, 8'h75); wr(0, 1'b1, 8'h02);
    wr(0, 1'b1, 8'hC2); wr(0, 1'b0, 8'h0A);
    pulseIr(0, 8'h96);
    rd(0, 1'b0, v); chk("a_irr", v, 8'h96);
    chk("a_int", {7'b0, intM}, 8'h01);
    intaFirst(c);
    chk("a_int_drop", {7'b0, intM}, 8'h00);
    rd(0, 1'b0, v); chk("a_irr_ack", v, 8'h92);
    intaSecond(v, vs); chk("a_vec1", v, 8'h72);
    chk("a_int_again", {7'b0, intM}, 8'h01);
    intaFirst(c); intaSecond(v, vs); chk("a_vec2", v, 8'h74);
    rd(0, 1'b1, v); chk("a_imr", v, 8'hC2);

    // edge mode, normal EOI, rotation and set-priority
    wr(0, 1'b0, 8'h12); wr(0, 1'b1, 8'h75); wr(0, 1'b1, 8'h00);
    wr(0, 1'b0, 8'h0B); wr(0, 1'b0, 8'h80);
    pulseIr(0, 8'h12);
    intaFirst(c); intaSecond(v, vs); chk("b_vec1", v, 8'h71);
    rd(0, 1'b0, v); chk("b_isr1", v, 8'h02);
    chk("b_int_blocked", {7'b0, intM}, 8'h00);
    wr(0, 1'b0, 8'hA0);
    rd(0, 1'b0, v); chk("b_isr_eoi", v, 8'h00);
    chk("b_int_ir4", {7'b0, intM}, 8'h01);
    pulseIr(0, 8'h01);
    intaFirst(c); intaSecond(v, vs); chk("b_vec_rot", v, 8'h74);
    rd(0, 1'b0, v); chk("b_isr4", v, 8'h10);
    wr(0, 1'b0, 8'h64);
    rd(0, 1'b0, v); chk("b_seoi", v, 8'h00);
    wr(0, 1'b0, 8'hC6);
    pulseIr(0, 8'h84);
    intaFirst(c); intaSecond(v, vs); chk("b_vec_prio", v, 8'h77);

    // fully masked request still latches but raises nothing
    wr(0, 1'b0, 8'h12); wr(0, 1'b1, 8'h75); wr(0, 1'b1, 8'hFF); wr(0, 1'b0, 8'h0A);
    pulseIr(0, 8'h01);
    chk("c_int_masked", {7'b0, intM}, 8'h00);
    rd(0, 1'b0, v); chk("c_irr", v, 8'h01);
    wr(0, 1'b1, 8'hFE);
    chk("c_int_unmask", {7'b0, intM}, 8'h01);
    intaFirst(c); intaSecond(v, vs); chk("c_vec", v, 8'h70);

    // cascade: slave on master IR1
    wr(0, 1'b0, 8'h19); wr(0, 1'b1, 8'h75); wr(0, 1'b1, 8'hFF);
    wr(0, 1'b1, 8'h02); wr(0, 1'b1, 8'h00);
    wr(1, 1'b0, 8'h19); wr(1, 1'b1, 8'h75); wr(1, 1'b1, 8'h01);
    wr(1, 1'b1, 8'h02); wr(1, 1'b1, 8'h00);
    pulseIr(1, 8'h02);
    chk("d_master_int", {7'b0, intM}, 8'h01);
    intaFirst(c); chk("d_cas", {5'b0, c}, 8'h01);
    intaSecond(v, vs);
    chk("d_slave_vec", vs, 8'h71);
    chk("d_master_hiz", v, 8'hFF);
    chk("d_int_idle", {7'b0, intM}, 8'h00);

    // reset while requesting, then writes before ICW1
    wr(0, 1'b0, 8'h12); wr(0, 1'b1, 8'h75); wr(0, 1'b1, 8'h00);
    pulseIr(0, 8'h01);
    chk("e_int_pre", {7'b0, intM}, 8'h01);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("e_rst_int", {7'b0, intM}, 8'h00);
    chk("e_rst_d", dM, 8'hFF);
    @(negedge clk); rst_n = 1'b1;
    wr(0, 1'b1, 8'h5A);
    rd(0, 1'b1, v); chk("e_imr_ignored", v, 8'h00);
    wr(0, 1'b0, 8'h12); wr(0, 1'b1, 8'h58); wr(0, 1'b1, 8'h00);
    pulseIr(0, 8'h01);
    intaFirst(c);
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    intaSecond(v, vs); chk("e_abort_novec", v, 8'hFF);

    // randomized: edge mode, AEOI, optional rotate-in-AEOI, random masks
    mBase = 5'($urandom_range(0, 31));
    mRotAeoi = 1'($urandom_range(0, 1));
    mIrr = 8'h00; mLowest = 7;
    wr(0, 1'b0, 8'h13); wr(0, 1'b1, {mBase, 3'b000}); wr(0, 1'b1, 8'h02);
    wr(0, 1'b0, 8'h0A); wr(0, 1'b0, mRotAeoi ? 8'h80 : 8'h00);
    for (int it = 0; it < 24; it++) begin
      mImr = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      wr(0, 1'b1, mImr);
      v = 8'($urandom_range(0, 255));
      pulseIr(0, v);
      mIrr = mIrr | v;
      rd(0, 1'b0, v); chk("rnd_irr", v, mIrr);
      pend = mIrr & ~mImr;
      chk("rnd_int", {7'b0, intM}, (pend != 8'h00) ? 8'h01 : 8'h00);
      if (pend != 8'h00) begin
        w = refWinner(pend, mLowest);
        expV = (8'(mBase) << 3) + 8'(w);
        intaFirst(c); intaSecond(v, vs);
        chk("rnd_vec", v, expV);
        mIrr[w] = 1'b0;
        if (mRotAeoi) mLowest = w;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pic8259.md
PIC8259 -- requirements
Module: pic8259

Interface
REQ-001 Single clock domain (clk); reset is asynchronous and active-low (rst_n).
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cas  inout  3  cascade ID bus; driven by the master, read by slaves.
REQ-005 d  inout  8  CPU data bus; high-Z unless this device is driving it.
REQ-006 rd_n  in  1  read strobe, active low.
REQ-007 wr_n  in  1  write strobe, active low.
REQ-008 a0  in  1  register select.
REQ-009 cs_n  in  1  chip select, active low.
REQ-010 sp_en  in  1  1 = master, 0 = slave (cascade mode only).
REQ-011 inta_n  in  1  interrupt-acknowledge pulses from the CPU, active low.
REQ-012 ir  in  8  interrupt request lines IR7..IR0.
REQ-013 int_o  out  1  interrupt request to the CPU, active high.

Function
REQ-014 A write is accepted once per strobe, on the first clk edge where cs_n=0 and wr_n=0 after a cycle where that condition was false; d is sampled on that edge.
REQ-015 Write decode:
- a0=0 with d[4]=1: ICW1 (d0=IC4, d1=SNGL, d3=LTIM). Restarts initialization, clears IMR, ISR, IRR, AEOI and rotation; selects IRR for reads; next write is ICW2.
- a0=1 after ICW1: ICW2; the vector base is d[7:3].
- ICW3 is expected only if SNGL=0. Master: slave bitmap. Slave: ID = d[2:0].
- ICW4 is expected only if IC4=1 (d1=AEOI); otherwise AEOI=0.
- When initialized: a0=1 is OCW1 (IMR=d); a0=0 with d[4:3]=00 is OCW2; a0=0 with d[4:3]=01 is OCW3 (if d1=1, RIS=d0).
REQ-016 OCW2 d[7:5]:
- 001: non-specific EOI.
- 011: specific EOI on level d[2:0].
- 101: non-specific EOI and rotate.
- 100: set rotate-in-AEOI.
- 000: clear rotate-in-AEOI.
- 111: specific EOI and rotate.
- 110: set priority; the lowest-priority level = d[2:0].
- 010: no operation.
REQ-017 IRR: in edge mode (LTIM=0) a bit is set on an ir rising edge, detected by clk sampling. In level mode a bit is set while ir is high. In both modes a bit stays latched until it is acknowledged. IMR does not block IRR latching.
REQ-018 Priority: IR0 highest by default. Rotation makes the serviced or EOI'd level lowest and its successor (mod 8) highest.
REQ-019 int_o=1 when the highest-priority unmasked IRR bit outranks every set ISR bit; otherwise 0.
REQ-020 First inta_n falling edge: latch the winner, set its ISR bit, clear its IRR bit, drop int_o.
REQ-021 Master with the winner on a slave-bitmap IR: drive cas = winner index from the first edge until the end of the second pulse. Otherwise cas is high-Z.
REQ-022 Second inta_n low pulse: drive d = {base, winner[2:0]}.
- A cascaded slave drives d only if cas equals its ID.
- A master does not drive d for a slave IR.
- If nothing was pending at the first edge, the vector uses level 7 (spurious).
REQ-023 On the second inta_n rising edge, with AEOI=1: clear the serviced ISR bit, and rotate if rotate-in-AEOI is set.
REQ-024 Reads (cs_n=0, rd_n=0): a0=1 returns IMR; a0=0 returns IRR (RIS=0) or ISR (RIS=1). d is high-Z otherwise.
REQ-025 Writes before ICW1 are ignored. A write during an INTA sequence applies immediately; the sequence continues.

Reset
REQ-026 Reset values:
- int_o=0; d and cas high-Z.
- IRR=ISR=IMR=00.
- AEOI=0, rotation off, IR0 highest, RIS=0.
- Not initialized; expects ICW1.
- INTA counter=0.
REQ-027 Reset asserted mid-INTA aborts the sequence with no vector.

Structure
REQ-028 Shared package pic8259_pkg: init-state enum (ICW1, ICW2, ICW3, ICW4, READY), ICW/OCW bit-position constants, OCW2 command codes.
REQ-029 One sub-module, pic8259_prio, combinationally resolves the winner from IRR, IMR, ISR and the rotation base.

Verification
REQ-030 Setup ICW1=1B, ICW2=75, ICW4=02, OCW1=C2, OCW3=0A, then pulse ir=96 and read a0=0:
- read returns 96 and int_o=1.
- After the first INTA, IRR reads 92.
- The second INTA returns d=72; int_o reasserts.
- The next INTA pair returns 74.
- A read with a0=1 returns C2.
REQ-031 Setup ICW1=12, ICW2=75, OCW1=00, OCW3=0B, OCW2=80, ir=12:
- INTA pair returns 71 and ISR reads 02.
- OCW2=A0 makes ISR read 00.
- Then pulse ir=01: the next INTA pair returns 74 (IR4 outranks IR0).
REQ-032 Master (sp_en=1): 19, 75, FF, 02, OCW1 00. Slave (sp_en=0): 19, 75, 01, 02, 00. Slave int_o feeds master ir[1]. Slave ir pulse 02:
- master int_o=1.
- cas=001 after the first INTA.
- Second INTA: slave drives 71, master stays high-Z.
REQ-033 OCW1=FF, ir=01 -> int_o stays 0; IRR reads 01.
REQ-034 rst_n low while int_o=1 -> int_o=0 and d is high-Z; a following write with a0=1 is ignored until ICW1.
